// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle RISC-V control unit.
// Holds the 4-bit state codes, the opcode/funct3/funct7 constants,
// the ALU_SELECTOR and ALU_SRCB encodings, and a helper that maps an
// R-type funct3/funct7 pair to its ALU operation.
package ctrl_pkg;

    // State codes; these values are visible on SAIDA_ESTADO.
    typedef logic [3:0] state_t;
    localparam state_t ST_RST    = 4'd0;
    localparam state_t ST_FETCH  = 4'd1;
    localparam state_t ST_DECODE = 4'd2;
    localparam state_t ST_R_EXEC = 4'd3;
    localparam state_t ST_I_EXEC = 4'd4;
    localparam state_t ST_ADDR   = 4'd5;
    localparam state_t ST_MEM_RD = 4'd6;
    localparam state_t ST_MEM_WR = 4'd7;
    localparam state_t ST_WB_ALU = 4'd8;
    localparam state_t ST_WB_MEM = 4'd9;
    localparam state_t ST_BRANCH = 4'd10;
    localparam state_t ST_HALT   = 4'd15;

    // Major opcodes understood by the control unit.
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BNE = 7'b1100111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_NOP = 3'b000,
        ALU_ADD = 3'b001,
        ALU_SUB = 3'b010,
        ALU_AND = 3'b011
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_REG    = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } srcb_t;

    // ALU_NOP flags an R-type funct combination the datapath cannot execute.
    function automatic alu_op_t r_alu_op(input logic [2:0] f3, input logic [6:0] f7);
        alu_op_t op;
        op = ALU_NOP;
        if (f3 == F3_ADD && f7 == F7_BASE)      op = ALU_ADD;
        else if (f3 == F3_ADD && f7 == F7_SUB)  op = ALU_SUB;
        else if (f3 == F3_AND && f7 == F7_BASE) op = ALU_AND;
        return op;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: bundle between the control unit and the datapath.
//   Datapath -> control : IR6_0, IR14_12, IR31_25, Igual
//   Control -> datapath : mux selects, register loads, memory strobe,
//                         SAIDA_ESTADO, HALT, ERR
// The master modport is the control unit, the slave modport the datapath.
interface multicycle_ctrl_if;
    logic [6:0]  IR6_0;
    logic [2:0]  IR14_12;
    logic [6:0]  IR31_25;
    logic        Igual;
    logic        ALU_SRCA;
    logic [1:0]  ALU_SRCB;
    logic [2:0]  ALU_SELECTOR;
    logic        PC_WRITE;
    logic        PC_SRC;
    logic        IR_WIRE;
    logic        LOAD_A;
    logic        LOAD_B;
    logic        LOAD_ALU_OUT;
    logic        LOAD_MDR;
    logic        MUX_MR_WIRE;
    logic        DMEM_RW;
    logic        BANCO_WIRE;
    logic [15:0] SAIDA_ESTADO;
    logic        HALT;
    logic        ERR;

    modport master (
        input  IR6_0, IR14_12, IR31_25, Igual,
        output ALU_SRCA, ALU_SRCB, ALU_SELECTOR, PC_WRITE, PC_SRC, IR_WIRE,
               LOAD_A, LOAD_B, LOAD_ALU_OUT, LOAD_MDR, MUX_MR_WIRE, DMEM_RW,
               BANCO_WIRE, SAIDA_ESTADO, HALT, ERR
    );

    modport slave (
        output IR6_0, IR14_12, IR31_25, Igual,
        input  ALU_SRCA, ALU_SRCB, ALU_SELECTOR, PC_WRITE, PC_SRC, IR_WIRE,
               LOAD_A, LOAD_B, LOAD_ALU_OUT, LOAD_MDR, MUX_MR_WIRE, DMEM_RW,
               BANCO_WIRE, SAIDA_ESTADO, HALT, ERR
    );
endinterface

// File: rtl/mem_wait_cnt.sv
// mem_wait_cnt: memory latency counter shared by instruction fetch and data read.
//   clk, rst : clock and synchronous active-high reset
//   clr      : return the count to zero
//   inc      : advance the count by one
//   done     : count has reached MEM_WAIT (memory data is valid this cycle)
module mem_wait_cnt #(
    parameter int MEM_WAIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic done
);
    logic [2:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= 3'd0;
        else if (inc)
            count <= count + 3'd1;
    end

    assign done = (count == 3'(MEM_WAIT));
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multicycle 64-bit RISC-V datapath.
//   CLK, RESET : clock and synchronous active-high reset
//   bus        : master side of multicycle_ctrl_if (instruction fields and
//                Igual in; every datapath strobe, state code, HALT, ERR out)
// MEM_WAIT is the number of extra cycles memory needs before Dataout is valid.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input logic CLK,
    input logic RESET,
    multicycle_ctrl_if.master bus
);
    state_t  state;
    state_t  next_state;
    logic    err_q;
    logic    set_err;
    logic    cnt_clr;
    logic    cnt_inc;
    logic    cnt_done;
    alu_op_t r_op;
    logic    branch_cond;

    mem_wait_cnt #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk  (CLK),
        .rst  (RESET),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .done (cnt_done)
    );

    assign r_op        = r_alu_op(bus.IR14_12, bus.IR31_25);
    assign branch_cond = (bus.IR6_0 == OP_BEQ) ? bus.Igual : !bus.Igual;

    // State and the sticky error flag; ERR only ever sets on the way into HALT.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_RST;
            err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (set_err)
                err_q <= 1'b1;
        end
    end

    // Strobe decode and next-state logic. Everything is forced low while
    // RESET is high so a reset landing mid-instruction never leaks a strobe.
    always_comb begin
        next_state       = state;
        set_err          = 1'b0;
        cnt_clr          = 1'b1;
        cnt_inc          = 1'b0;
        bus.ALU_SRCA     = 1'b0;
        bus.ALU_SRCB     = SRCB_REG;
        bus.ALU_SELECTOR = ALU_NOP;
        bus.PC_WRITE     = 1'b0;
        bus.PC_SRC       = 1'b0;
        bus.IR_WIRE      = 1'b0;
        bus.LOAD_A       = 1'b0;
        bus.LOAD_B       = 1'b0;
        bus.LOAD_ALU_OUT = 1'b0;
        bus.LOAD_MDR     = 1'b0;
        bus.MUX_MR_WIRE  = 1'b0;
        bus.DMEM_RW      = 1'b0;
        bus.BANCO_WIRE   = 1'b0;
        bus.SAIDA_ESTADO = 16'd0;
        bus.HALT         = 1'b0;
        bus.ERR          = 1'b0;
        if (!RESET) begin
            bus.SAIDA_ESTADO = {12'd0, state};
            bus.ERR          = err_q;
            case (state)
                ST_RST: next_state = ST_FETCH;
                ST_FETCH: begin
                    cnt_clr = cnt_done;
                    cnt_inc = !cnt_done;
                    if (cnt_done) begin
                        bus.IR_WIRE      = 1'b1;
                        bus.ALU_SRCB     = SRCB_FOUR;
                        bus.ALU_SELECTOR = ALU_ADD;
                        bus.LOAD_ALU_OUT = 1'b1;
                        next_state       = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    // PC takes the PC+4 latched in FETCH while ALU_OUT is
                    // overwritten with the branch target from the old PC.
                    bus.PC_WRITE     = 1'b1;
                    bus.PC_SRC       = 1'b1;
                    bus.LOAD_A       = 1'b1;
                    bus.LOAD_B       = 1'b1;
                    bus.ALU_SRCB     = SRCB_IMM_SH;
                    bus.ALU_SELECTOR = ALU_ADD;
                    bus.LOAD_ALU_OUT = 1'b1;
                    case (bus.IR6_0)
                        OP_R:          next_state = ST_R_EXEC;
                        OP_I:          next_state = ST_I_EXEC;
                        OP_LD, OP_SD:  next_state = ST_ADDR;
                        OP_BEQ, OP_BNE: next_state = ST_BRANCH;
                        OP_SYS:        next_state = ST_HALT;
                        default: begin
                            next_state = ST_HALT;
                            set_err    = 1'b1;
                        end
                    endcase
                end
                ST_R_EXEC: begin
                    if (r_op == ALU_NOP) begin
                        next_state = ST_HALT;
                        set_err    = 1'b1;
                    end else begin
                        bus.ALU_SRCA     = 1'b1;
                        bus.ALU_SELECTOR = r_op;
                        bus.LOAD_ALU_OUT = 1'b1;
                        next_state       = ST_WB_ALU;
                    end
                end
                ST_I_EXEC: begin
                    if (bus.IR14_12 != F3_ADD) begin
                        next_state = ST_HALT;
                        set_err    = 1'b1;
                    end else begin
                        bus.ALU_SRCA     = 1'b1;
                        bus.ALU_SRCB     = SRCB_IMM;
                        bus.ALU_SELECTOR = ALU_ADD;
                        bus.LOAD_ALU_OUT = 1'b1;
                        next_state       = ST_WB_ALU;
                    end
                end
                ST_ADDR: begin
                    bus.ALU_SRCA     = 1'b1;
                    bus.ALU_SRCB     = SRCB_IMM;
                    bus.ALU_SELECTOR = ALU_ADD;
                    bus.LOAD_ALU_OUT = 1'b1;
                    if (bus.IR6_0 == OP_LD)
                        next_state = ST_MEM_RD;
                    else if (bus.IR6_0 == OP_SD)
                        next_state = ST_MEM_WR;
                    else begin
                        next_state = ST_HALT;
                        set_err    = 1'b1;
                    end
                end
                ST_MEM_RD: begin
                    cnt_clr = cnt_done;
                    cnt_inc = !cnt_done;
                    if (cnt_done) begin
                        bus.LOAD_MDR = 1'b1;
                        next_state   = ST_WB_MEM;
                    end
                end
                ST_MEM_WR: begin
                    bus.DMEM_RW = 1'b1;
                    next_state  = ST_FETCH;
                end
                ST_WB_ALU: begin
                    bus.BANCO_WIRE = 1'b1;
                    next_state     = ST_FETCH;
                end
                ST_WB_MEM: begin
                    bus.BANCO_WIRE  = 1'b1;
                    bus.MUX_MR_WIRE = 1'b1;
                    next_state      = ST_FETCH;
                end
                ST_BRANCH: begin
                    bus.ALU_SRCA     = 1'b1;
                    bus.ALU_SELECTOR = ALU_SUB;
                    bus.PC_SRC       = 1'b1;
                    bus.PC_WRITE     = branch_cond;
                    next_state       = ST_FETCH;
                end
                ST_HALT: bus.HALT = 1'b1;
                default: begin
                    next_state = ST_HALT;
                    set_err    = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl.
// The reference model expands each instruction into the list of cycles it
// should take (fetch wait, decode, class-specific steps) and the strobes
// each of those cycles must show; the DUT is compared once per cycle.
module tb_multicycle_ctrl;
    localparam int MW = 1;

    typedef struct packed {
        logic [15:0] st;
        logic        srca;
        logic [1:0]  srcb;
        logic [2:0]  sel;
        logic        pcw, pcs, irw, la, lb, lao, lmdr, mux, rw, banco, halt, err;
    } obs_t;

    logic clk;
    logic reset;
    obs_t dut_obs;
    obs_t exp_q[$];
    int   compared;
    int   mismatched;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_WAIT(MW)) dut (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus)
    );

    assign dut_obs = '{st: bus.SAIDA_ESTADO, srca: bus.ALU_SRCA, srcb: bus.ALU_SRCB,
                       sel: bus.ALU_SELECTOR, pcw: bus.PC_WRITE, pcs: bus.PC_SRC,
                       irw: bus.IR_WIRE, la: bus.LOAD_A, lb: bus.LOAD_B,
                       lao: bus.LOAD_ALU_OUT, lmdr: bus.LOAD_MDR, mux: bus.MUX_MR_WIRE,
                       rw: bus.DMEM_RW, banco: bus.BANCO_WIRE, halt: bus.HALT, err: bus.ERR};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t in_state(input int s);
        obs_t o;
        o    = '0;
        o.st = 16'(s);
        return o;
    endfunction

    task automatic checkOutput(input obs_t exp, input string tag);
        compared++;
        assert (dut_obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, dut_obs, exp);
        end
    endtask

    // Expected cycle list for one instruction, pushed onto exp_q.
    task automatic modelInstr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic ig, input int halt_len, output bit halted);
        obs_t e;
        bit   ill;
        ill    = 1'b0;
        halted = 1'b0;
        for (int i = 0; i <= MW; i++) begin
            e = in_state(1);
            if (i == MW) begin
                e.irw = 1'b1; e.srcb = 2'b01; e.sel = 3'd1; e.lao = 1'b1;
            end
            exp_q.push_back(e);
        end
        e = in_state(2);
        e.pcw = 1'b1; e.pcs = 1'b1; e.la = 1'b1; e.lb = 1'b1;
        e.srcb = 2'b11; e.sel = 3'd1; e.lao = 1'b1;
        exp_q.push_back(e);
        case (op)
            7'b0110011: begin
                e = in_state(3);
                if (f3 == 3'd0 && f7 == 7'h00)      e.sel = 3'd1;
                else if (f3 == 3'd0 && f7 == 7'h20) e.sel = 3'd2;
                else if (f3 == 3'd7 && f7 == 7'h00) e.sel = 3'd3;
                else ill = 1'b1;
                if (!ill) begin e.srca = 1'b1; e.lao = 1'b1; end
                exp_q.push_back(e);
                if (!ill) begin e = in_state(8); e.banco = 1'b1; exp_q.push_back(e); end
            end
            7'b0010011: begin
                e = in_state(4);
                if (f3 != 3'd0) ill = 1'b1;
                else begin e.srca = 1'b1; e.srcb = 2'b10; e.sel = 3'd1; e.lao = 1'b1; end
                exp_q.push_back(e);
                if (!ill) begin e = in_state(8); e.banco = 1'b1; exp_q.push_back(e); end
            end
            7'b0000011, 7'b0100011: begin
                e = in_state(5);
                e.srca = 1'b1; e.srcb = 2'b10; e.sel = 3'd1; e.lao = 1'b1;
                exp_q.push_back(e);
                if (op == 7'b0000011) begin
                    for (int i = 0; i <= MW; i++) begin
                        e = in_state(6);
                        e.lmdr = (i == MW);
                        exp_q.push_back(e);
                    end
                    e = in_state(9); e.banco = 1'b1; e.mux = 1'b1;
                    exp_q.push_back(e);
                end else begin
                    e = in_state(7); e.rw = 1'b1;
                    exp_q.push_back(e);
                end
            end
            7'b1100011, 7'b1100111: begin
                e = in_state(10);
                e.srca = 1'b1; e.sel = 3'd2; e.pcs = 1'b1;
                e.pcw  = (op == 7'b1100011) ? ig : !ig;
                exp_q.push_back(e);
            end
            7'b1110011: halted = 1'b1;
            default:    ill = 1'b1;
        endcase
        if (ill) halted = 1'b1;
        if (halted) begin
            for (int i = 0; i < halt_len; i++) begin
                e = in_state(15); e.halt = 1'b1; e.err = ill;
                exp_q.push_back(e);
            end
        end
    endtask

    // Drive one instruction and compare every cycle the model predicts.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic ig, input int halt_len, input string tag,
                                 output bit halted);
        bus.IR6_0   = op;
        bus.IR14_12 = f3;
        bus.IR31_25 = f7;
        bus.Igual   = ig;
        modelInstr(op, f3, f7, ig, halt_len, halted);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            checkOutput(exp_q.pop_front(), tag);
        end
    endtask

    task automatic doReset(input string tag);
        reset = 1'b1;
        @(negedge clk);
        checkOutput(in_state(0), {tag, "_hold1"});
        @(negedge clk);
        checkOutput(in_state(0), {tag, "_hold2"});
        reset = 1'b0;
        #1;
        checkOutput(in_state(0), {tag, "_rst_state"});
    endtask

    initial begin
        bit         h;
        int         cls;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        compared    = 0;
        mismatched  = 0;
        reset       = 1'b1;
        bus.IR6_0   = 7'd0;
        bus.IR14_12 = 3'd0;
        bus.IR31_25 = 7'd0;
        bus.Igual   = 1'b0;

        doReset("por");
        applyStimulus(7'b0110011, 3'b000, 7'b0000000, 1'b0, 0, "add", h);
        applyStimulus(7'b0110011, 3'b000, 7'b0100000, 1'b0, 0, "sub", h);
        applyStimulus(7'b0110011, 3'b111, 7'b0000000, 1'b1, 0, "and", h);
        applyStimulus(7'b0010011, 3'b000, 7'b1010101, 1'b0, 0, "addi", h);
        applyStimulus(7'b0000011, 3'b011, 7'b0000000, 1'b0, 0, "ld", h);
        applyStimulus(7'b0100011, 3'b011, 7'b0000000, 1'b1, 0, "sd", h);
        applyStimulus(7'b1100011, 3'b000, 7'b0000000, 1'b1, 0, "beq_taken", h);
        applyStimulus(7'b1100011, 3'b000, 7'b0000000, 1'b0, 0, "beq_not", h);
        applyStimulus(7'b1100111, 3'b001, 7'b0000000, 1'b1, 0, "bne_not", h);
        applyStimulus(7'b1100111, 3'b001, 7'b0000000, 1'b0, 0, "bne_taken", h);
        applyStimulus(7'b1110011, 3'b000, 7'b0000000, 1'b0, 10, "break", h);
        doReset("after_break");
        applyStimulus(7'b1111111, 3'b000, 7'b0000000, 1'b0, 4, "illegal_op", h);
        doReset("after_illegal");
        applyStimulus(7'b0110011, 3'b001, 7'b0000000, 1'b0, 3, "bad_funct", h);
        doReset("after_bad_funct");

        // Reset during the first MEM_RD cycle: no LOAD_MDR/BANCO_WIRE may
        // follow, and the next fetch must wait the full latency again.
        bus.IR6_0   = 7'b0000011;
        bus.IR14_12 = 3'b011;
        bus.IR31_25 = 7'd0;
        modelInstr(7'b0000011, 3'b011, 7'd0, 1'b0, 0, h);
        for (int i = 0; i < MW + 4; i++) begin
            @(negedge clk);
            checkOutput(exp_q.pop_front(), "ld_pre_reset");
        end
        exp_q.delete();
        reset = 1'b1;
        #1;
        checkOutput(in_state(0), "ld_reset_gate");
        doReset("ld_mid_reset");
        applyStimulus(7'b0110011, 3'b000, 7'b0000000, 1'b0, 0, "add_after_reset", h);

        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(0, 10);
            f3  = 3'($urandom);
            f7  = 7'($urandom);
            case (cls)
                0: begin op = 7'b0110011; f3 = 3'b000; f7 = 7'b0000000; end
                1: begin op = 7'b0110011; f3 = 3'b000; f7 = 7'b0100000; end
                2: begin op = 7'b0110011; f3 = 3'b111; f7 = 7'b0000000; end
                3: op = 7'b0110011;
                4: begin op = 7'b0010011; f3 = 3'b000; end
                5: op = 7'b0010011;
                6: op = 7'b0000011;
                7: op = 7'b0100011;
                8: op = 7'b1100011;
                9: op = 7'b1100111;
                default: op = 7'($urandom);
            endcase
            applyStimulus(op, f3, f7, 1'($urandom), 2, "random", h);
            if (h) doReset("random_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control FSM that sequences the 64-bit RISC-V datapath: instruction fetch, decode, execute, memory access and write-back for add/sub/and/addi/ld/sd/beq/bne/break. It sits beside the datapath top, drives every mux select, register load and memory strobe, and stalls on memory latency with an internal wait counter. Illegal opcodes halt the core with an error flag.

Parameters:
MEM_WAIT, 1, extra cycles between a stable memory address and valid Dataout (range 0..7); applies to both instruction and data reads.

Ports:
CLK  in  1  clock
RESET  in  1  synchronous reset, active-high
IR6_0  in  7  opcode from the instruction register
IR14_12  in  3  funct3
IR31_25  in  7  funct7
Igual  in  1  ALU equality flag (A==B)
ALU_SRCA  out  1  0=PC, 1=reg A
ALU_SRCB  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=imm<<1
ALU_SELECTOR  out  3  ALU op code (see package)
PC_WRITE  out  1  PC load enable
PC_SRC  out  1  PC input select: 0=ALU S, 1=ALU_OUT register
IR_WIRE  out  1  instruction register load
LOAD_A  out  1  reg A load
LOAD_B  out  1  reg B load
LOAD_ALU_OUT  out  1  ALU_OUT register load
LOAD_MDR  out  1  memory data register load
MUX_MR_WIRE  out  1  write-back select: 0=ALU_OUT, 1=MDR
DMEM_RW  out  1  data memory: 0=read, 1=write
BANCO_WIRE  out  1  register file write enable
SAIDA_ESTADO  out  16  current state code, zero-extended
HALT  out  1  core stopped (sticky until RESET)
ERR  out  1  halt was caused by an illegal instruction

Behaviour:
- RESET=1 at edge -> state=RST(0), wait counter=0, HALT=ERR=0. All outputs are 0 while in RST and during any cycle with RESET high. RST -> FETCH unconditionally.
- State codes: RST 0, FETCH 1, DECODE 2, R_EXEC 3, I_EXEC 4, ADDR 5, MEM_RD 6, MEM_WR 7, WB_ALU 8, WB_MEM 9, BRANCH 10, HALT 15. All strobes default to 0.
- FETCH: counter increments each cycle. When the counter reaches MEM_WAIT: IR_WIRE=1, SRCA=0, SRCB=01, ADD, LOAD_ALU_OUT=1 (ALU_OUT<=PC+4). Clear the counter and go to DECODE. FETCH lasts MEM_WAIT+1 cycles.
- DECODE: PC_WRITE=1, PC_SRC=1 (PC<=old ALU_OUT=PC+4). LOAD_A=LOAD_B=1. SRCA=0, SRCB=11, ADD, LOAD_ALU_OUT=1 (branch target from the pre-update PC, same edge). Next state by opcode: 0110011->R_EXEC; 0010011->I_EXEC; 0000011 or 0100011->ADDR; 1100011 or 1100111->BRANCH; 1110011->HALT (ERR=0); any other opcode->HALT with ERR=1.
- R_EXEC: SRCA=1, SRCB=00, LOAD_ALU_OUT=1. ALU op: funct3 000 with funct7 0000000 -> ADD; funct3 000 with funct7 0100000 -> SUB; funct3 111 with funct7 0000000 -> AND. Then WB_ALU. Any other funct combination -> HALT with ERR=1 and no load.
- I_EXEC: funct3 must be 000, else HALT with ERR=1. SRCA=1, SRCB=10, ADD, LOAD_ALU_OUT=1, then WB_ALU.
- WB_ALU: BANCO_WIRE=1, MUX_MR_WIRE=0, then FETCH. WB_MEM: BANCO_WIRE=1, MUX_MR_WIRE=1, then FETCH.
- ADDR: SRCA=1, SRCB=10, ADD, LOAD_ALU_OUT=1. Load opcode -> MEM_RD; store opcode -> MEM_WR.
- MEM_RD: DMEM_RW=0. Counter counts to MEM_WAIT; LOAD_MDR=1 on the final cycle, then WB_MEM.
- MEM_WR: DMEM_RW=1 for exactly 1 cycle, then FETCH.
- BRANCH: SRCA=1, SRCB=00, SUB. Condition is Igual for opcode 1100011 (beq) and !Igual for 1100111 (bne). PC_WRITE = condition, combinational on Igual; PC_SRC=1. Then FETCH.
- HALT: all strobes 0 and HALT=1. Stays in HALT until RESET; ERR holds its value.
- RESET in any state, including mid-wait, overrides everything on the next edge; no partial strobe is issued in that cycle.

Decomposition:
- Package ctrl_pkg holds: the state enum (4-bit codes above), the opcode/funct3/funct7 localparams, the ALU_SELECTOR encoding (ADD=001, SUB=010, AND=011), and the SRCB encoding.
- One natural sub-module, mem_wait_cnt: a counter with clear, increment and done at MEM_WAIT, shared by FETCH and MEM_RD.

Test Plan:
- RESET high 2 cycles -> all outputs 0, SAIDA_ESTADO=0. Release -> 1 cycle in state 0, then SAIDA_ESTADO=1.
- MEM_WAIT=1, add (0110011/000/0000000) -> FETCH 2 cycles (IR_WIRE on the 2nd), DECODE, R_EXEC with ALU_SELECTOR=001, WB_ALU with BANCO_WIRE=1 and MUX_MR_WIRE=0; back in FETCH after 5 cycles. Same flow with funct7=0100000 -> ALU_SELECTOR=010.
- ld (0000011) -> ADDR with SRCB=10; MEM_RD for 2 cycles with LOAD_MDR only on the 2nd; WB_MEM with MUX_MR_WIRE=1. sd (0100011) -> DMEM_RW=1 for exactly 1 cycle.
- beq with Igual=1 -> PC_WRITE=1 and PC_SRC=1 in BRANCH; with Igual=0 -> PC_WRITE=0. bne (1100111) gives the inverse.
- 1110011 -> HALT=1, ERR=0, held for 10 cycles. Opcode 1111111 -> HALT=1, ERR=1. RESET then returns to state 0 with ERR=0.
- RESET asserted in the 1st MEM_RD cycle -> next cycle SAIDA_ESTADO=0, LOAD_MDR and BANCO_WIRE never asserted, counter restarts at 0 in FETCH.
